// File: rtl/thirty_two_bit_one_to_two_demux_router.sv
// Purpose : 1:2 demux router. Each input word is steered to output A (in_select=0)
//           or output B (in_select=1). Each output is buffered by its own DEPTH-entry
//           first-word-fall-through FIFO.
// Latency : 1 cycle from input acceptance to x_valid/x_data. There is no bypass path.
// Backpr. : in_ready = !full of the selected FIFO. It never depends on a_ready/b_ready,
//           and a full side never blocks the other side.
// Ports   : clk, rst (async, active-low)
//           in_data/in_select/in_valid/in_ready  producer side
//           a_data/a_valid/a_ready               consumer A
//           b_data/b_valid/b_ready               consumer B
// Option  : `define DEMUX_STATS_EN adds a_count/b_count (16-bit wrapping totals of
//           words accepted per side).

module thirty_two_bit_one_to_two_demux_router_fifo #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   output logic         full_o,
   input  logic         pop_i,
   output logic [W-1:0] head_dat_o,
   output logic         head_vld_o
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_fire, pop_fire, empty;

   assign empty     = (cnt_q == '0);
   assign full_o    = (cnt_q == CNT_FULL);
   // A pop request against an empty FIFO is ignored, so an empty FIFO with a
   // simultaneous push and pop only pushes.
   assign pop_fire  = pop_i && !empty;
   assign push_fire = push_i && !full_o;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_fire && !pop_fire) cnt_d = cnt_q + CNT_ONE;
      if (pop_fire && !push_fire) cnt_d = cnt_q - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage has no reset. Stale contents are hidden because the head is masked while empty.
   always_ff @(posedge clk) begin
      if (push_fire) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_vld_o = !empty;
   assign head_dat_o = empty ? '0 : mem_q[rd_ptr_q];
endmodule

module thirty_two_bit_one_to_two_demux_router #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_data,
   input  logic        in_select,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] a_data,
   output logic        a_valid,
   input  logic        a_ready,
   output logic [31:0] b_data,
   output logic        b_valid,
   input  logic        b_ready
`ifdef DEMUX_STATS_EN
   ,
   output logic [15:0] a_count,
   output logic [15:0] b_count
`endif
);
   logic a_full, b_full;
   logic a_push, b_push;

   // Only the selected side's fullness matters. There is deliberately no
   // pass-through when full, which keeps in_ready independent of x_ready.
   assign in_ready = in_select ? !b_full : !a_full;
   assign a_push   = in_valid && in_ready && !in_select;
   assign b_push   = in_valid && in_ready &&  in_select;

   thirty_two_bit_one_to_two_demux_router_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo_a (
      .clk        (clk),
      .rst        (rst),
      .push_i     (a_push),
      .push_dat_i (in_data),
      .full_o     (a_full),
      .pop_i      (a_ready),
      .head_dat_o (a_data),
      .head_vld_o (a_valid)
   );

   thirty_two_bit_one_to_two_demux_router_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo_b (
      .clk        (clk),
      .rst        (rst),
      .push_i     (b_push),
      .push_dat_i (in_data),
      .full_o     (b_full),
      .pop_i      (b_ready),
      .head_dat_o (b_data),
      .head_vld_o (b_valid)
   );

`ifdef DEMUX_STATS_EN
   logic [15:0] a_count_q, a_count_d;
   logic [15:0] b_count_q, b_count_d;

   always_comb begin
      a_count_d = a_count_q;
      b_count_d = b_count_q;
      if (a_push) a_count_d = a_count_q + 16'd1;
      if (b_push) b_count_d = b_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_count_q <= '0;
         b_count_q <= '0;
      end else begin
         a_count_q <= a_count_d;
         b_count_q <= b_count_d;
      end
   end

   assign a_count = a_count_q;
   assign b_count = b_count_q;
`endif
endmodule

// File: tb/tb_thirty_two_bit_one_to_two_demux_router.sv
module tb_thirty_two_bit_one_to_two_demux_router;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_select, in_valid, in_ready;
   logic [31:0] a_data, b_data;
   logic        a_valid, a_ready, b_valid, b_ready;
`ifdef DEMUX_STATS_EN
   logic [15:0] a_count, b_count;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: one queue per output, plus wrapping per-side totals.
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic [15:0] tot_a = 16'd0;
   logic [15:0] tot_b = 16'd0;

   always #5 clk = ~clk;

   thirty_two_bit_one_to_two_demux_router #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_select (in_select),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_data    (a_data),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .b_data    (b_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready)
`ifdef DEMUX_STATS_EN
      ,
      .a_count   (a_count),
      .b_count   (b_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic model_rdy(input logic sel);
      return sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
   endfunction

   task automatic check_outputs();
      chk("in_ready", {31'd0, in_ready}, {31'd0, model_rdy(in_select)});
      chk("a_valid", {31'd0, a_valid}, {31'd0, qa.size() > 0});
      chk("a_data", a_data, (qa.size() > 0) ? qa[0] : 32'h0);
      chk("b_valid", {31'd0, b_valid}, {31'd0, qb.size() > 0});
      chk("b_data", b_data, (qb.size() > 0) ? qb[0] : 32'h0);
`ifdef DEMUX_STATS_EN
      chk("a_count", {16'd0, a_count}, {16'd0, tot_a});
      chk("b_count", {16'd0, b_count}, {16'd0, tot_b});
`endif
   endtask

   // Called just after a falling edge. Drives the inputs, checks the outputs
   // mid-cycle, then advances the model across the rising edge.
   task automatic step(input logic v, input logic s, input logic [31:0] d,
                       input logic ar, input logic br);
      logic acc, pa, pb;
      in_valid = v; in_select = s; in_data = d; a_ready = ar; b_ready = br;
      #1;
      check_outputs();
      acc = v && model_rdy(s);
      pa  = ar && (qa.size() > 0);
      pb  = br && (qb.size() > 0);
      @(posedge clk);
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      if (acc) begin
         if (s) begin qb.push_back(d); tot_b = tot_b + 16'd1; end
         else   begin qa.push_back(d); tot_a = tot_a + 16'd1; end
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      qa.delete(); qb.delete(); tot_a = 16'd0; tot_b = 16'd0;
   endtask

   initial begin
      in_valid = 1'b1; in_select = 1'b0; in_data = 32'hFFFF_FFFF;
      a_ready = 1'b0; b_ready = 1'b0;
      rst = 1'b0;
      // Reset is held low while a word is offered. Nothing may be captured.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
      chk("rst_a_data", a_data, 32'h0);
      chk("rst_b_data", b_data, 32'h0);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      in_select = 1'b0; #1 chk("rst_rdy_sel0", {31'd0, in_ready}, 32'd1);
      in_select = 1'b1; #1 chk("rst_rdy_sel1", {31'd0, in_ready}, 32'd1);
      @(negedge clk);

      // Basic routing.
      step(1, 0, 32'hDEADBEEF, 1, 1);
      chk("basic_a", a_data, 32'hDEADBEEF);
      step(1, 1, 32'h12345678, 1, 1);
      chk("basic_a_gone", {31'd0, a_valid}, 32'd0);
      chk("basic_b", b_data, 32'h12345678);
      step(0, 0, 32'h0, 1, 1);
      step(0, 0, 32'h0, 1, 1);

      // Fill A while its consumer is stalled. B must keep flowing.
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            in_select = 1'b0; #1 chk("full_rdy0", {31'd0, in_ready}, 32'd0);
         end
         step(1, 0, 32'hA000_0000 + i, 0, 0);
      end
      step(1, 1, 32'hB0B0_0001, 0, 0);
      chk("indep_b", b_data, 32'hB0B0_0001);
      // Popping in the same cycle must not reopen a full side.
      in_select = 1'b0; a_ready = 1'b1; #1
      chk("full_no_passthru", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", a_data, 32'hA000_0000 + i);
         step(0, 0, 32'h0, 1, 1);
      end

      // Simultaneous push/pop with two words resident.
      step(1, 0, 32'hC000_0000, 0, 0);
      step(1, 0, 32'hC000_0001, 0, 0);
      for (int i = 2; i < 12; i++) begin
         in_select = 1'b0; #1 chk("pp_rdy", {31'd0, in_ready}, 32'd1);
         step(1, 0, 32'hC000_0000 + i, 1, 0);
         chk("pp_count", qa.size(), 32'd2);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 1);

      // Reset between edges. Valids must drop without a clock edge.
      step(1, 0, 32'h1, 0, 0);
      step(1, 0, 32'h2, 0, 0);
      step(1, 0, 32'h3, 0, 0);
      step(1, 1, 32'h4, 0, 0);
      in_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("mid_rst_b_valid", {31'd0, b_valid}, 32'd0);
      chk("mid_rst_a_data", a_data, 32'h0);
      #1 rst = 1'b1;
      @(negedge clk);
      step(1, 0, 32'h5151_5151, 0, 0);
      step(1, 0, 32'h5252_5252, 0, 0);
      step(1, 0, 32'h5353_5353, 0, 0);
      step(1, 1, 32'h5454_5454, 0, 0);
      chk("post_rst_a_head", a_data, 32'h5151_5151);
`ifdef DEMUX_STATS_EN
      chk("stats_a3", {16'd0, a_count}, 32'd3);
      chk("stats_b1", {16'd0, b_count}, 32'd1);
`endif

      // Randomized traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
      end
      for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 1, 1);

`ifdef DEMUX_STATS_EN
      // Push A until the counter reaches 16'hFFFF, then push once more to check the wrap.
      while (tot_a != 16'hFFFF) step(1, 0, 32'h0, 1, 1);
      step(0, 0, 32'h0, 1, 1);
      chk("stats_ffff", {16'd0, a_count}, 32'h0000_FFFF);
      step(1, 0, 32'h0, 1, 1);
      chk("stats_wrap", {16'd0, a_count}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
